// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/state enums and flag bit indices shared by alu_seq and its core
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SHL  = 4'b0000,
        OP_SHR  = 4'b0001,
        OP_ROL  = 4'b0010,
        OP_ROR  = 4'b0011,
        OP_ASR  = 4'b0100,
        OP_RSV5 = 4'b0101,
        OP_RSV6 = 4'b0110,
        OP_RSV7 = 4'b0111,
        OP_PASS = 4'b1000,
        OP_ADD  = 4'b1001,
        OP_SUB  = 4'b1010,
        OP_NEG  = 4'b1011,
        OP_OR   = 4'b1100,
        OP_AND  = 4'b1101,
        OP_XOR  = 4'b1110,
        OP_NOT  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_shift(input op_e op);
        return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR};
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - single-cycle ALU ops and {Z,N,C,V} flags
// ALU_BARREL_EN adds a one-cycle barrel shifter; otherwise shift ops pass A (shamt==0 case).
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e                      i_op,
    input  logic [WIDTH-1:0]         i_a,
    input  logic [WIDTH-1:0]         i_b,
`ifdef ALU_BARREL_EN
    input  logic [$clog2(WIDTH)-1:0] i_shamt,
`endif
    output logic [WIDTH-1:0]         o_result,
    output logic [3:0]               o_flags
);

    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_c;
    logic             w_v;

`ifdef ALU_BARREL_EN
    localparam int SW = $clog2(WIDTH);
    logic [SW:0] w_inv;
    assign w_inv = (SW+1)'(WIDTH) - {1'b0, i_shamt};
`endif

    always_comb begin
        w_res = '0;
        w_sum = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_op)
`ifdef ALU_BARREL_EN
            // the extra bit beside the operand catches the last bit shifted out
            OP_SHL: {w_c, w_res} = {1'b0, i_a} << i_shamt;
            OP_SHR: {w_res, w_c} = {i_a, 1'b0} >> i_shamt;
            OP_ASR: {w_res, w_c} = $signed({i_a, 1'b0}) >>> i_shamt;
            OP_ROL: begin
                w_res = (i_a << i_shamt) | (i_a >> w_inv);
                w_c   = (i_shamt != '0) & w_res[0];
            end
            OP_ROR: begin
                w_res = (i_a >> i_shamt) | (i_a << w_inv);
                w_c   = (i_shamt != '0) & w_res[WIDTH-1];
            end
`else
            OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: w_res = i_a;
`endif
            OP_PASS: w_res = i_a;
            OP_ADD: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum = {1'b0, i_a} - {1'b0, i_b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_NEG: begin
                w_res = '0 - i_a;
                w_c   = (i_a != '0);
                w_v   = (i_a == MSB_ONLY);
            end
            OP_OR:   w_res = i_a | i_b;
            OP_AND:  w_res = i_a & i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            OP_NOT:  w_res = ~i_a;
            default: w_res = '0;
        endcase
    end

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_Z] = (w_res == '0);
        o_flags[FLAG_N] = w_res[WIDTH-1];
        o_flags[FLAG_C] = w_c;
        o_flags[FLAG_V] = w_v;
    end

    assign o_result = w_res;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered shift/rotate/arith ALU with valid/ready handshake
// ALU_BARREL_EN: all ops single-cycle; otherwise shifts/rotates iterate one bit per cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags
);

    state_e             r_state;
    state_e             w_next;
    op_e                r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    op_e                w_op;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_core_res;
    logic [3:0]         w_core_flags;
    logic [WIDTH-1:0]   w_step_acc;
    logic               w_step_c;
    logic               w_accept;
    logic               w_start_shift;

    assign w_op = op_e'(op);

    // only a non-power-of-two WIDTH can present shamt >= WIDTH
    generate
        if (WIDTH == (1 << SHAMT_W)) begin : g_shamt_full
            assign w_shamt = shamt;
        end else begin : g_shamt_clamp
            assign w_shamt = (shamt > SHAMT_W'(WIDTH - 1)) ? SHAMT_W'(WIDTH - 1) : shamt;
        end
    endgenerate

`ifdef ALU_BARREL_EN
    assign w_start_shift = 1'b0;
`else
    assign w_start_shift = is_shift(w_op) && (w_shamt != '0);
`endif

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .i_op     (w_op),
        .i_a      (a),
        .i_b      (b),
`ifdef ALU_BARREL_EN
        .i_shamt  (w_shamt),
`endif
        .o_result (w_core_res),
        .o_flags  (w_core_flags)
    );

    always_comb begin
        w_step_acc = r_acc;
        w_step_c   = 1'b0;
        case (r_op)
            OP_SHL: begin w_step_acc = {r_acc[WIDTH-2:0], 1'b0};         w_step_c = r_acc[WIDTH-1]; end
            OP_SHR: begin w_step_acc = {1'b0, r_acc[WIDTH-1:1]};         w_step_c = r_acc[0];       end
            OP_ROL: begin w_step_acc = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]}; w_step_c = r_acc[WIDTH-1]; end
            OP_ROR: begin w_step_acc = {r_acc[0], r_acc[WIDTH-1:1]};     w_step_c = r_acc[0];       end
            OP_ASR: begin w_step_acc = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]}; w_step_c = r_acc[0];     end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = w_start_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (r_cnt == SHAMT_W'(1)) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_next = in_valid ? (w_start_shift ? SHIFT : DONE) : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_SHL;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            if (w_start_shift) begin
                r_op  <= w_op;
                r_acc <= a;
                r_cnt <= w_shamt;
            end else begin
                r_result <= w_core_res;
                r_flags  <= w_core_flags;
            end
        end else if (r_state == SHIFT) begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt - SHAMT_W'(1);
            if (r_cnt == SHAMT_W'(1)) begin
                r_result <= w_step_acc;
                r_flags  <= {(w_step_acc == '0), w_step_acc[WIDTH-1], w_step_c, 1'b0};
            end
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq against a reference model
module tb_alu_seq;

    localparam int W  = 8;
    localparam int SW = $clog2(W);
    localparam longint MASK = (64'sd1 <<< W) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    flags;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           acc_cyc;
        int           lat;
        bit           seen;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {result, Z, N, C, V}
    function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] av,
                                           input logic [W-1:0] bv, input logic [SW-1:0] sh);
        longint ua, ub, sa, sb, r, t, smax, smin;
        int s;
        logic c, v;
        logic [W-1:0] rr;
        ua = longint'(av);
        ub = longint'(bv);
        sa = av[W-1] ? ua - (MASK + 1) : ua;
        sb = bv[W-1] ? ub - (MASK + 1) : ub;
        smax = (MASK + 1) / 2 - 1;
        smin = -((MASK + 1) / 2);
        s = (int'(sh) > W - 1) ? W - 1 : int'(sh);
        c = 1'b0;
        v = 1'b0;
        case (o)
            4'd0: begin t = ua << s; r = t & MASK; c = ((t >> W) & 1) != 0; end
            4'd1: begin r = ua >> s; c = (s > 0) && (((ua >> (s - 1)) & 1) != 0); end
            4'd2: begin r = ((ua << s) | (ua >> (W - s))) & MASK; c = (s > 0) && ((r & 1) != 0); end
            4'd3: begin r = ((ua >> s) | (ua << (W - s))) & MASK; c = (s > 0) && (((r >> (W - 1)) & 1) != 0); end
            4'd4: begin r = (sa >>> s) & MASK; c = (s > 0) && (((ua >> (s - 1)) & 1) != 0); end
            4'd8: r = ua;
            4'd9: begin r = (ua + ub) & MASK; c = (ua + ub) > MASK; v = (sa + sb > smax) || (sa + sb < smin); end
            4'd10: begin r = (ua - ub) & MASK; c = ua < ub; v = (sa - sb > smax) || (sa - sb < smin); end
            4'd11: begin r = (-ua) & MASK; c = ua != 0; v = (-sa) > smax; end
            4'd12: r = ua | ub;
            4'd13: r = ua & ub;
            4'd14: r = ua ^ ub;
            4'd15: r = (~ua) & MASK;
            default: r = 0;
        endcase
        rr = r[W-1:0];
        return {rr, (rr == '0), rr[W-1], c, v};
    endfunction

    function automatic int lat_of(input logic [3:0] o, input logic [SW-1:0] sh);
        int s;
        s = (int'(sh) > W - 1) ? W - 1 : int'(sh);
`ifdef ALU_BARREL_EN
        return 1;
`else
        return (o <= 4'd4 && s != 0) ? s + 1 : 1;
`endif
    endfunction

    // Compare process: every cycle a result is presented it must match the oldest expectation
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got out_valid=1 result=0x%0h, required no result", result);
            end else begin
                if (!exp_q[0].seen) begin
                    chk("latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
                    exp_q[0].seen = 1'b1;
                end
                chk("result", result, exp_q[0].res);
                chk("flags", flags, exp_q[0].fl);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Starts and ends just after a rising edge
    task automatic send(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [SW-1:0] sh, input logic [W-1:0] lr, input logic [3:0] lf);
        logic [W+3:0] m;
        exp_t e;
        int n;
        m = model(o, av, bv, sh);
        chk("model_pin", 32'(m), 32'({lr, lf}));
        in_valid = 1'b1;
        op = o;
        a = av;
        b = bv;
        shamt = sh;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, required 1 within 100 cycles");
        end else begin
            e.res = m[W+3:4];
            e.fl = m[3:0];
            e.acc_cyc = cyc;
            e.lat = lat_of(o, sh);
            e.seen = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        shamt = '0;
        op = 4'b0110;
    endtask

    task automatic check_busy(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("in_ready_busy", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic bad;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", result, '0);
        chk("reset_flags", flags, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // back-to-back single-cycle ops
        send(4'b1001, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0101);
        send(4'b1010, 8'h00, 8'h01, 3'd0, 8'hFF, 4'b0110);
        send(4'b1011, 8'h80, 8'h00, 3'd0, 8'h80, 4'b0111);
        send(4'b1010, 8'h80, 8'h01, 3'd0, 8'h7F, 4'b0001);
        send(4'b1001, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1010);
        send(4'b1000, 8'h00, 8'h55, 3'd0, 8'h00, 4'b1000);
        send(4'b1111, 8'h0F, 8'h00, 3'd0, 8'hF0, 4'b0100);
        send(4'b1100, 8'h50, 8'h0A, 3'd0, 8'h5A, 4'b0000);
        send(4'b0110, 8'h12, 8'h34, 3'd0, 8'h00, 4'b1000);
        send(4'b0001, 8'h81, 8'h00, 3'd0, 8'h81, 4'b0100);
        drain();

        // shifts and rotates, including shamt==WIDTH-1
        send(4'b0011, 8'h01, 8'h00, 3'd1, 8'h80, 4'b0110);
        check_busy(lat_of(4'b0011, 3'd1) - 1);
        send(4'b0100, 8'h90, 8'h00, 3'd2, 8'hE4, 4'b0100);
        check_busy(lat_of(4'b0100, 3'd2) - 1);
        send(4'b0010, 8'h81, 8'h00, 3'd1, 8'h03, 4'b0010);
        check_busy(lat_of(4'b0010, 3'd1) - 1);
        send(4'b0000, 8'h01, 8'h00, 3'd7, 8'h80, 4'b0100);
        check_busy(lat_of(4'b0000, 3'd7) - 1);
        send(4'b0001, 8'h80, 8'h00, 3'd7, 8'h01, 4'b0000);
        check_busy(lat_of(4'b0001, 3'd7) - 1);
        drain();

        // consumer stall holds result/flags, then accept-while-draining
        out_ready = 1'b0;
        send(4'b1101, 8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0000);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'b1110, 8'hF0, 8'hFF, 3'd0, 8'h0F, 4'b0000);
        drain();

        // reset during an iterative shift aborts it
        send(4'b0000, 8'h81, 8'h00, 3'd7, 8'h80, 4'b0100);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_result", result, '0);
        chk("rst_mid_flags", flags, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("rst_mid_no_result", bad, 1'b0);
        chk("rst_mid_result_after", result, '0);
        @(posedge clk);
        #1;
        send(4'b0000, 8'h81, 8'h00, 3'd1, 8'h02, 4'b0010);
        check_busy(lat_of(4'b0000, 3'd1) - 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
